// File: rtl/rlc_decoder_param.sv
// Run-length decoder: unpacks (value, run) symbols from an SRAM word stream
// into one packed block of N_OUT values, flagging runs that overrun the block.
module rlc_decoder_param #(
    parameter int unsigned VAL_W = 4,
    parameter int unsigned RUN_W = 2,
    parameter int unsigned N_OUT = 8,
    parameter int unsigned IN_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [IN_W-1:0]          sram_din,
    input  logic                     sram_valid,
    output logic                     sram_req,
    output logic [N_OUT*VAL_W-1:0]   out,
    output logic                     done,
    output logic                     busy,
    output logic                     run_err
);

    localparam int unsigned SYM_W = VAL_W + RUN_W;
    localparam int unsigned BUF_W = 2 * IN_W;
    localparam int unsigned OUT_W = N_OUT * VAL_W;
    localparam int unsigned CNT_W = $clog2(BUF_W + 1);
    localparam int unsigned OC_W  = $clog2(N_OUT + 1);

    localparam logic [CNT_W-1:0] SYM_C  = CNT_W'(SYM_W);
    localparam logic [CNT_W-1:0] IN_C   = CNT_W'(IN_W);
    localparam logic [OC_W-1:0]  LAST_C = OC_W'(N_OUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StZeros,
        StFinish,
        StDrain
    } state_e;

    state_e           state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d, buf_c;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d, bitcnt_c;
    logic             pend_q, pend_d;
    logic [OUT_W-1:0] sr_q, sr_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [OC_W-1:0]  ocnt_q, ocnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             err_q, err_d;

    logic             active;
    logic             accept;
    logic             have_sym;
    logic             consume;
    logic             last;
    logic [VAL_W-1:0] sym_val;
    logic [RUN_W-1:0] sym_run;

    always_comb begin
        active   = (state_q == StFetch) || (state_q == StDecode) || (state_q == StZeros);
        // Room check is bitcnt + IN_W <= 2*IN_W, folded to avoid counter overflow.
        sram_req = active && !pend_q && (bitcnt_q <= IN_C);
        accept   = sram_valid && pend_q;
        have_sym = bitcnt_q >= SYM_C;
        consume  = ((state_q == StFetch) || (state_q == StDecode)) && have_sym;
        last     = ocnt_q == LAST_C;
        sym_val  = buf_q[BUF_W-1 -: VAL_W];
        sym_run  = buf_q[BUF_W-VAL_W-1 -: RUN_W];

        state_d = state_q;
        sr_d    = sr_q;
        out_d   = out_q;
        ocnt_d  = ocnt_q;
        run_d   = run_q;
        err_d   = err_q;
        pend_d  = sram_req ? 1'b1 : (accept ? 1'b0 : pend_q);

        buf_c    = consume ? (buf_q << SYM_W) : buf_q;
        bitcnt_c = consume ? (bitcnt_q - SYM_C) : bitcnt_q;
        // New word lands directly below the bits still valid after this cycle's consume.
        if (accept && active) begin
            buf_d    = buf_c | ({sram_din, {IN_W{1'b0}}} >> bitcnt_c);
            bitcnt_d = bitcnt_c + IN_C;
        end else begin
            buf_d    = buf_c;
            bitcnt_d = bitcnt_c;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StFetch;
                    sr_d     = '0;
                    ocnt_d   = '0;
                    err_d    = 1'b0;
                    buf_d    = '0;
                    bitcnt_d = '0;
                end
            end
            StFetch, StDecode: begin
                if (!have_sym) begin
                    state_d = StFetch;
                end else begin
                    sr_d   = {sr_q[OUT_W-VAL_W-1:0], sym_val};
                    ocnt_d = ocnt_q + OC_W'(1);
                    run_d  = sym_run;
                    if (last) begin
                        state_d = StFinish;
                        out_d   = sr_d;
                        if (sym_run != '0) begin
                            err_d = 1'b1;
                        end
                    end else if (sym_run != '0) begin
                        state_d = StZeros;
                    end else begin
                        state_d = StDecode;
                    end
                end
            end
            StZeros: begin
                sr_d   = {sr_q[OUT_W-VAL_W-1:0], {VAL_W{1'b0}}};
                ocnt_d = ocnt_q + OC_W'(1);
                run_d  = run_q - RUN_W'(1);
                if (last) begin
                    state_d = StFinish;
                    out_d   = sr_d;
                    if (run_q != RUN_W'(1)) begin
                        err_d = 1'b1;
                    end
                end else if (run_q == RUN_W'(1)) begin
                    state_d = StDecode;
                end
            end
            StFinish: begin
                // Leftover bits are dropped so the next block starts word-aligned.
                buf_d    = '0;
                bitcnt_d = '0;
                state_d  = (pend_q && !sram_valid) ? StDrain : StIdle;
            end
            StDrain: begin
                if (sram_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            buf_q    <= '0;
            bitcnt_q <= '0;
            pend_q   <= 1'b0;
            sr_q     <= '0;
            out_q    <= '0;
            ocnt_q   <= '0;
            run_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            bitcnt_q <= bitcnt_d;
            pend_q   <= pend_d;
            sr_q     <= sr_d;
            out_q    <= out_d;
            ocnt_q   <= ocnt_d;
            run_q    <= run_d;
            err_q    <= err_d;
        end
    end

    assign out     = out_q;
    assign done    = (state_q == StFinish);
    assign busy    = (state_q != StIdle);
    assign run_err = err_q;

endmodule
